// File: rtl/icache_refill_assembler.sv
// Assembles BEAT_NUM downstream rxdat beats into one icache line tagged with its MSHR entry.
// Optional per-beat even-parity checking is built when ICACHE_REFILL_PARITY_EN is defined.
module icache_refill_assembler #(
  parameter int LINE_WIDTH      = 512,
  parameter int BEAT_WIDTH      = 256,
  parameter int BEAT_NUM        = LINE_WIDTH / BEAT_WIDTH,
  parameter int ENTRY_IDX_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rxdat_vld,
  output logic                       rxdat_rdy,
  input  logic [BEAT_WIDTH-1:0]      rxdat_data,
  input  logic [ENTRY_IDX_WIDTH-1:0] rxdat_entry_id,
  input  logic                       rxdat_par,
  output logic                       refill_vld,
  input  logic                       refill_rdy,
  output logic [LINE_WIDTH-1:0]      refill_data,
  output logic [ENTRY_IDX_WIDTH-1:0] refill_entry_id,
  output logic                       refill_err,
  output logic                       proto_err
);

  localparam int CNT_W = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEAT_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OUTPUT
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CNT_W-1:0]           r_beat_cnt;
  logic [CNT_W-1:0]           w_beat_cnt_nxt;
  logic                       r_rxdat_rdy;
  logic                       r_refill_vld;
  logic                       r_proto_err;
  logic [LINE_WIDTH-1:0]      r_line;
  logic [ENTRY_IDX_WIDTH-1:0] r_entry_id;

  logic w_beat_acc;
  logic w_line_acc;
  logic w_last_beat;
  logic w_id_mismatch;

  assign w_beat_acc    = rxdat_vld & r_rxdat_rdy;
  assign w_line_acc    = r_refill_vld & refill_rdy;
  assign w_last_beat   = (r_beat_cnt == LAST_SLOT);
  assign w_id_mismatch = (r_state == COLLECT) & w_beat_acc & (rxdat_entry_id != r_entry_id);

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_beat_acc) begin
          w_beat_cnt_nxt = CNT_W'(1);
          w_state_nxt    = COLLECT;
        end
      end
      COLLECT: begin
        // The counter parks on the last slot while the line waits, so it never wraps.
        if (w_beat_acc) begin
          if (w_last_beat) begin
            w_state_nxt = OUTPUT;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          end
        end
      end
      OUTPUT: begin
        if (w_line_acc) begin
          w_state_nxt    = IDLE;
          w_beat_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so they never see rxdat_vld or refill_rdy combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_rxdat_rdy  <= 1'b1;
      r_refill_vld <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_rxdat_rdy  <= (w_state_nxt != OUTPUT);
      r_refill_vld <= (w_state_nxt == OUTPUT);
      if (w_id_mismatch) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < BEAT_NUM; k++) begin
      if (w_beat_acc && (r_beat_cnt == CNT_W'(k))) begin
        r_line[k*BEAT_WIDTH +: BEAT_WIDTH] <= rxdat_data;
      end
    end
    if (w_beat_acc && (r_state == IDLE)) begin
      r_entry_id <= rxdat_entry_id;
    end
  end

`ifdef ICACHE_REFILL_PARITY_EN
  logic r_err_acc;
  logic w_par_bad;

  assign w_par_bad = w_beat_acc & ((^rxdat_data) ^ rxdat_par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_acc <= 1'b0;
    end else if (w_line_acc) begin
      r_err_acc <= 1'b0;
    end else if (w_par_bad) begin
      r_err_acc <= 1'b1;
    end
  end

  assign refill_err = r_err_acc;
`else
  logic w_unused_par;

  assign w_unused_par = rxdat_par;
  assign refill_err   = 1'b0;
`endif

  assign rxdat_rdy       = r_rxdat_rdy;
  assign refill_vld      = r_refill_vld;
  assign refill_data     = r_line;
  assign refill_entry_id = r_entry_id;
  assign proto_err       = r_proto_err;

endmodule

// File: doc/icache_refill_assembler.md
# icache_refill_assembler

Collects the multi-beat refill data returned on the downstream rxdat channel of the icache and assembles it into one full cache line, tagged with its MSHR entry index. It sits directly behind the icache downstream rxdat port and feeds the line-fill path (data-array write and MSHR release) through a single valid/ready refill interface. One line is buffered at a time. While a completed line waits to be accepted, downstream data is back-pressured.

## Interface
Parameters:
- LINE_WIDTH, 512, cache line width in bits.
- BEAT_WIDTH, 256, downstream rxdat beat width in bits. LINE_WIDTH must be an integer multiple of BEAT_WIDTH.
- BEAT_NUM, LINE_WIDTH/BEAT_WIDTH, beats per line. Must be ≥ 2.
- ENTRY_IDX_WIDTH, 3, MSHR entry index width.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- rxdat_vld, in, 1, downstream beat valid.
- rxdat_rdy, out, 1, beat accepted when `rxdat_vld && rxdat_rdy`.
- rxdat_data, in, BEAT_WIDTH, beat payload.
- rxdat_entry_id, in, ENTRY_IDX_WIDTH, MSHR entry the beat belongs to.
- rxdat_par, in, 1, even parity over rxdat_data. Used only with the parity macro.
- refill_vld, out, 1, assembled line valid.
- refill_rdy, in, 1, line consumer ready.
- refill_data, out, LINE_WIDTH, assembled line. Beat k occupies bits [k*BEAT_WIDTH +: BEAT_WIDTH].
- refill_entry_id, out, ENTRY_IDX_WIDTH, entry id latched from beat 0.
- refill_err, out, 1, parity error seen on any beat of the line. Valid with refill_vld.
- proto_err, out, 1, sticky flag: an entry id changed mid-line. Cleared only by reset.

## Operation
- The downstream interface delivers all beats of one line contiguously and in order (beat 0 first). Lines are never interleaved.
- FSM states: IDLE, COLLECT, OUTPUT.
- IDLE:
  - rxdat_rdy=1.
  - On an accepted beat: write the beat to slot 0, latch entry id, set beat_cnt=1, go to COLLECT.
- COLLECT:
  - rxdat_rdy=1.
  - Each accepted beat is written to slot beat_cnt, and beat_cnt increments.
  - When the beat written is slot BEAT_NUM-1, go to OUTPUT.
- OUTPUT:
  - rxdat_rdy=0, refill_vld=1.
  - On `refill_vld && refill_rdy`, go to IDLE; beat_cnt and the error accumulator clear.
- beat_cnt is $clog2(BEAT_NUM) bits wide (minimum 1). It never wraps: the transition to OUTPUT occurs at slot BEAT_NUM-1.
- An accepted beat in COLLECT whose rxdat_entry_id differs from the latched id:
  - sets proto_err;
  - the beat is still stored in the current line;
  - the latched id is unchanged.
- refill_data, refill_entry_id and refill_err are held stable from refill_vld rising until the handshake completes.
- Data registers are not reset; only the FSM, beat_cnt, the error accumulator and proto_err are reset.

## Timing
- Reset values (asynchronous on rst_n low): state=IDLE, rxdat_rdy=1, refill_vld=0, refill_err=0, proto_err=0, beat_cnt=0. refill_data and refill_entry_id are undefined.
- Reset asserted mid-line or while in OUTPUT discards the partial or pending line. There is no output afterward.
- Latency: last beat accepted in cycle N gives refill_vld=1 in cycle N+1.
- Minimum line period is BEAT_NUM+1 cycles: BEAT_NUM beat cycles plus one output cycle with a same-cycle refill_rdy.
- rxdat_rdy is a registered function of state only. It never depends combinationally on rxdat_vld or refill_rdy.
- In OUTPUT with refill_rdy=0, the block stalls indefinitely; rxdat_rdy stays 0 and outputs hold.
- A beat presented in the cycle after a handshake (state back in IDLE) is accepted.
- rxdat_vld gaps between beats are allowed; beat_cnt holds.

## Configuration
- ICACHE_REFILL_PARITY_EN defined:
  - each accepted beat is checked (^rxdat_data ^ rxdat_par must be 0);
  - any mismatch sets the line's error accumulator, which drives refill_err in OUTPUT.
- Not defined:
  - refill_err is constant 0;
  - rxdat_par is ignored;
  - no parity logic is synthesised.

## Test plan
- After reset, two beats 0xA…A / 0xB…B on entry 3 with no gaps → refill_vld in the cycle after beat 1; refill_data={B…B,A…A}; refill_entry_id=3; refill_err=0.
- refill_rdy held 0 for 5 cycles in OUTPUT while rxdat_vld=1 → rxdat_rdy=0 throughout; outputs stable; after refill_rdy=1, the next beat is accepted in the following cycle.
- Beat 0 on entry 2, beat 1 on entry 5 → proto_err=1 and stays 1; refill_entry_id=2; line still delivered.
- With ICACHE_REFILL_PARITY_EN, a wrong rxdat_par on beat 1 → refill_err=1 for that line only; the next clean line has refill_err=0. Without the macro, refill_err=0.
- rst_n pulsed low after beat 0 → rxdat_rdy=1, refill_vld=0; a new 2-beat line on entry 7 assembles correctly with id 7.
- Back-to-back lines with refill_rdy tied 1 → one line every 3 cycles; entry ids and data match in order.
